// File: rtl/c16_loader_pkg.sv
// Shared definitions for the c16 instruction-memory loader: the frame FSM states,
// the SYNC marker and the widths of the frame fields.
package c16_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;
    localparam int WORD_W = 16;

    localparam logic [BYTE_W-1:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter for the loader: cleared on every accepted byte (or outside a frame),
// flags expiry on the cycle whose edge would bring the count to LIMIT.
module loader_timeout #(
    parameter int LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    // Saturates at LIMIT-1 so the flag stays up until the FSM reacts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader driving the write port of the c16 instruction RAM.
// Define IMEM_LOADER_CHECKSUM_EN to require and verify a trailing checksum byte.
module imem_loader
    import c16_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              load_ok,
    output logic              load_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t FRAME_END = ST_CHK;
`else
    localparam loader_state_t FRAME_END = ST_DONE;
`endif

    loader_state_t state, state_next;

    logic              accept;
    logic              in_frame;
    logic              timed_out;
    logic [BYTE_W-1:0] addr_hi;
    logic [BYTE_W-1:0] cnt_hi;
    logic [BYTE_W-1:0] data_hi;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  words_left;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] chk_sum;
`endif

    assign in_ready = (state != ST_DONE) && (state != ST_ERR);
    assign accept   = in_valid && in_ready;
    assign in_frame = (state != ST_IDLE) && in_ready;

    loader_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept || !in_frame),
        .expired(timed_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (accept && in_data == LOADER_SYNC) state_next = ST_ADDR_HI;
            ST_ADDR_HI: if (accept) state_next = ST_ADDR_LO;
            ST_ADDR_LO: if (accept) state_next = ST_CNT_HI;
            ST_CNT_HI:  if (accept) state_next = ST_CNT_LO;
            ST_CNT_LO:  if (accept) state_next = ({cnt_hi, in_data} == '0) ? FRAME_END : ST_DATA_HI;
            ST_DATA_HI: if (accept) state_next = ST_DATA_LO;
            ST_DATA_LO: if (accept) state_next = (words_left == CNT_W'(1)) ? FRAME_END : ST_DATA_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK:     if (accept) state_next = ((chk_sum + in_data) == '0) ? ST_DONE : ST_ERR;
`endif
            ST_DONE:    state_next = ST_IDLE;
            ST_ERR:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        // A byte arriving on the expiry cycle still counts; only a silent cycle aborts.
        if (in_frame && timed_out && !accept) begin
            state_next = ST_ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wren   <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            cpu_hold   <= 1'b0;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
            addr_hi    <= '0;
            cnt_hi     <= '0;
            data_hi    <= '0;
            wr_addr    <= '0;
            words_left <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_sum    <= '0;
`endif
        end else begin
            mem_wren <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && in_data == LOADER_SYNC) begin
                        cpu_hold <= 1'b1;
                        load_ok  <= 1'b0;
                        load_err <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_sum  <= '0;
`endif
                    end
                end
                ST_ADDR_HI: if (accept) addr_hi <= in_data;
                ST_ADDR_LO: if (accept) wr_addr <= {addr_hi, in_data};
                ST_CNT_HI:  if (accept) cnt_hi <= in_data;
                ST_CNT_LO:  if (accept) words_left <= {cnt_hi, in_data};
                ST_DATA_HI: if (accept) data_hi <= in_data;
                ST_DATA_LO: begin
                    if (accept) begin
                        mem_wren   <= 1'b1;
                        mem_addr   <= wr_addr;
                        mem_data   <= {data_hi, in_data};
                        wr_addr    <= wr_addr + ADDR_W'(1);
                        words_left <= words_left - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    load_ok  <= 1'b1;
                    cpu_hold <= 1'b0;
                end
                ST_ERR: begin
                    load_err <= 1'b1;
                    cpu_hold <= 1'b0;
                end
                default: ;
            endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept && state != ST_IDLE) begin
                chk_sum <= chk_sum + in_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames checked against a frame-parsing model.
// Honours IMEM_LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic        cpu_hold;
    logic        load_ok;
    logic        load_err;

    imem_loader #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_wren(mem_wren),
        .cpu_hold(cpu_hold),
        .load_ok (load_ok),
        .load_err(load_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model outputs: expected {addr,data} writes, status 0=none 1=ok 2=err, byte indices
    logic [31:0] exp_wr[$];
    int          exp_status;
    int          exp_sync;
    int          exp_fin;
    int          acc_cyc[$];

    int   hold_rise, hold_fall, ok_rise, err_rise, last_wren;
    int   wren_cycs[$];
    logic prev_hold = 1'b0, prev_wren = 1'b0, prev_ok = 1'b0, prev_err = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Parses a byte list by the frame rules: skip to SYNC, header, CNT words, optional CHK.
    function automatic void modelStream(input byte_q_t s);
        int          i;
        logic [7:0]  sum;
        logic [15:0] base;
        logic [15:0] cnt;
        i = 0;
        exp_status = 0;
        exp_sync = -1;
        exp_fin = -1;
        exp_wr.delete();
        while (i < s.size() && s[i] != 8'hA5) i++;
        if (i >= s.size()) return;
        exp_sync = i;
        i++;
        if (i + 4 > s.size()) return;
        base = {s[i], s[i+1]};
        cnt  = {s[i+2], s[i+3]};
        sum  = s[i] + s[i+1] + s[i+2] + s[i+3];
        i += 4;
        exp_fin = i - 1;
        for (int w = 0; w < int'(cnt); w++) begin
            if (i + 2 > s.size()) return;
            exp_wr.push_back({base + 16'(w), s[i], s[i+1]});
            sum = sum + s[i] + s[i+1];
            i += 2;
            exp_fin = i - 1;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (i >= s.size()) return;
        sum = sum + s[i];
        exp_fin = i;
        exp_status = (sum == 8'h00) ? 1 : 2;
`else
        exp_status = 1;
`endif
    endfunction

    // Per-cycle compare of the write port plus edge bookkeeping for the frame checks.
    always @(negedge clk) begin
        if (mem_wren) begin
            if (exp_wr.size() == 0) begin
                checkOutput("write_expected", {mem_addr, mem_data}, 32'hFFFF_FFFF);
            end else begin
                checkOutput("write", {mem_addr, mem_data}, exp_wr.pop_front());
            end
            checkOutput("write_under_hold", cpu_hold, 1);
            checkOutput("wren_single_cycle", prev_wren, 0);
            last_wren = cyc;
            wren_cycs.push_back(cyc);
        end
        if (cpu_hold && !prev_hold) hold_rise = cyc;
        if (!cpu_hold && prev_hold) hold_fall = cyc;
        if (load_ok && !prev_ok)    ok_rise = cyc;
        if (load_err && !prev_err)  err_rise = cyc;
        prev_hold = cpu_hold;
        prev_wren = mem_wren;
        prev_ok   = load_ok;
        prev_err  = load_err;
    end

    task automatic clearEvents();
        hold_rise = -1;
        hold_fall = -1;
        ok_rise   = -1;
        err_rise  = -1;
        last_wren = -1;
        wren_cycs.delete();
    endtask

    // Offers each byte at a negedge (after an optional random gap) until it is taken.
    task automatic applyStimulus(input byte_q_t s, input int max_gap);
        int g;
        bit taken;
        acc_cyc.delete();
        foreach (s[k]) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            taken = 1'b0;
            in_valid = 1'b0;
            repeat (g) @(negedge clk);
            for (int t = 0; t < 20 && !taken; t++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = s[k];
                taken    = in_ready;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            if (!taken) checkOutput("byte_accepted", 0, 1);
            else acc_cyc.push_back(cyc);
        end
    endtask

    task automatic runFrame(input string name, input byte_q_t s, input int max_gap);
        int sc, fc;
        modelStream(s);
        clearEvents();
        applyStimulus(s, max_gap);
        repeat (4) @(posedge clk);
        #1;
        checkOutput({name, "_writes_left"}, exp_wr.size(), 0);
        checkOutput({name, "_load_ok"}, load_ok, exp_status == 1);
        checkOutput({name, "_load_err"}, load_err, exp_status == 2);
        checkOutput({name, "_hold_low"}, cpu_hold, 0);
        if (exp_sync >= 0 && exp_fin >= 0 && exp_fin < acc_cyc.size()) begin
            sc = acc_cyc[exp_sync];
            fc = acc_cyc[exp_fin];
            checkOutput({name, "_hold_rise"}, hold_rise, sc);
            checkOutput({name, "_hold_fall"}, hold_fall, fc + 1);
            checkOutput({name, "_flag_rise"}, (exp_status == 1) ? ok_rise : err_rise, fc + 1);
        end
        if (wren_cycs.size() > 0) checkOutput({name, "_wren_before_release"}, last_wren < hold_fall, 1);
        if (max_gap == 0 && wren_cycs.size() >= 2) checkOutput({name, "_write_spacing"}, wren_cycs[1] - wren_cycs[0], 2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        byte_q_t basic, badchk, wrapf, zerof, junk, tof, rstf;
        int      fc;
        basic  = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h30};
        badchk = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h31};
        wrapf  = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
        zerof  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        junk   = '{8'h00, 8'hFF};
        tof    = '{8'hA5, 8'h00, 8'h10};
        rstf   = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        clearEvents();
        #3;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_mem_wren", mem_wren, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_mem_data", mem_data, 0);
        checkOutput("reset_cpu_hold", cpu_hold, 0);
        checkOutput("reset_flags", {load_ok, load_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed values that pin the model itself
        modelStream(basic);
        checkOutput("model_basic_n", exp_wr.size(), 2);
        checkOutput("model_basic_w0", exp_wr[0], 32'h0010_1234);
        checkOutput("model_basic_w1", exp_wr[1], 32'h0011_ABCD);
        checkOutput("model_basic_status", exp_status, 1);
        modelStream(badchk);
`ifdef IMEM_LOADER_CHECKSUM_EN
        checkOutput("model_badchk_status", exp_status, 2);
`else
        checkOutput("model_badchk_status", exp_status, 1);
`endif
        modelStream(wrapf);
        checkOutput("model_wrap_w0", exp_wr[0], 32'hFFFF_0102);
        checkOutput("model_wrap_w1", exp_wr[1], 32'h0000_0304);
        checkOutput("model_wrap_status", exp_status, 1);

        runFrame("basic", basic, 0);
        runFrame("bad_chk", badchk, 0);
        runFrame("wrap", wrapf, 0);
        runFrame("zero_cnt", zerof, 0);

        // Garbage before SYNC is dropped without starting a frame
        modelStream(junk);
        clearEvents();
        applyStimulus(junk, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("junk_taken", acc_cyc.size(), 2);
        checkOutput("junk_no_hold", hold_rise, -1);
        checkOutput("junk_ok_kept", load_ok, 1);
        checkOutput("junk_in_ready", in_ready, 1);

        runFrame("gappy", basic, 4);

        // Stall after ADDR_LO: 16 silent edges enter ERR, flags register one edge later
        modelStream(tof);
        clearEvents();
        applyStimulus(tof, 0);
        fc = acc_cyc[2];
        for (int t = 0; t < 40 && !load_err; t++) @(negedge clk);
        #1;
        checkOutput("timeout_err_cycle", err_rise - fc, 17);
        checkOutput("timeout_hold_fall", hold_fall - fc, 17);
        checkOutput("timeout_ok", load_ok, 0);

        // Reset while the loader waits for DATA_LO of the second word
        modelStream(rstf);
        clearEvents();
        applyStimulus(rstf, 0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_outputs", {in_ready, mem_wren, cpu_hold, load_ok, load_err}, 5'b10000);
        checkOutput("midreset_addr_data", {mem_addr, mem_data}, 32'h0);
        checkOutput("midreset_write_seen", wren_cycs.size(), 1);
        @(negedge clk);
        rst_n = 1'b1;
        runFrame("after_reset", basic, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
